// File: rtl/piso_serializer_8bit_pkg.sv
// rtl/piso_serializer_8bit_pkg.sv - shared types and frame constants for the PISO serializer
// Purpose: FSM state type, default word width, frame length and counter width.
// Optional feature macro: PISO_PARITY_EN adds one even-parity bit per frame.
package piso_serializer_8bit_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int WIDTH_DEFAULT = 8;

`ifdef PISO_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  localparam int FRAME_DEFAULT = WIDTH_DEFAULT + PARITY_BITS;
  localparam int CNT_W_DEFAULT = $clog2(FRAME_DEFAULT + 1);

  // Frame length in serial cycles for a given data width.
  function automatic int frame_len(input int width);
    return width + PARITY_BITS;
  endfunction

  // Counter width able to hold every bit index of the frame.
  function automatic int cnt_width(input int width);
    return $clog2(width + PARITY_BITS + 1);
  endfunction

endpackage

// File: rtl/piso_serializer_8bit_counter.sv
// rtl/piso_serializer_8bit_counter.sv - frame bit counter with terminal-count flag
// Purpose: counts transmitted bits of the current frame; last flags bit TERMINAL.
// Ports: clk, rst (sync, active-high), clr (sync clear), inc (increment enable),
//        count (current bit index), last (count == TERMINAL).
module piso_bit_counter #(
  parameter int CNT_W    = 4,
  parameter int TERMINAL = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

  assign last = (count == CNT_W'(TERMINAL));

endmodule

// File: rtl/piso_serializer_8bit.sv
// rtl/piso_serializer_8bit.sv - parallel-in/serial-out transmitter with load handshake
// Purpose: accepts a WIDTH-bit word on load_valid & load_ready and shifts it out
//          one bit per clock, qualified by serial_valid; done marks the final bit.
// Ports: clk, rst (sync, active-high), in (parallel word), load_valid, load_ready,
//        serial_out, serial_valid, busy (frame in progress), done (last-bit pulse).
// Optional feature macro: PISO_PARITY_EN appends an even-parity bit to each frame.
module piso_serializer_8bit
  import piso_serializer_8bit_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             done
);

  localparam int FRAME = frame_len(WIDTH);
  localparam int CNT_W = cnt_width(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q;
  logic [CNT_W-1:0]   count;
  logic               last;
  logic               accept;
  logic               data_bit;
  logic               tx_bit;

  piso_bit_counter #(
    .CNT_W    (CNT_W),
    .TERMINAL (FRAME - 1)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .inc   ((state_q == SHIFT) && !last),
    .count (count),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Shift toward the output end with zero fill; a reload on the last bit
  // takes priority so streaming frames stay gap-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
    end else if (accept) begin
      shreg_q <= in;
    end else if (state_q == SHIFT) begin
      shreg_q <= LSB_FIRST ? {1'b0, shreg_q[WIDTH-1:1]} : {shreg_q[WIDTH-2:0], 1'b0};
    end
  end

  assign data_bit = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];

`ifdef PISO_PARITY_EN
  // Parity is taken from the word at capture, since the shift register
  // has been emptied by the time the parity slot is reached.
  logic parity_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= ^in;
    end
  end

  assign tx_bit = (count == CNT_W'(WIDTH)) ? parity_q : data_bit;
`else
  assign tx_bit = data_bit;
`endif

  // Outputs are forced low while rst is high so an aborted frame stops
  // in the reset cycle itself rather than one edge later.
  always_comb begin
    state_d      = state_q;
    load_ready   = 1'b0;
    serial_out   = 1'b0;
    serial_valid = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          load_ready = 1'b1;
        end
        SHIFT: begin
          serial_valid = 1'b1;
          busy         = 1'b1;
          serial_out   = tx_bit;
          done         = last;
          load_ready   = last;
        end
        default: begin
          load_ready = 1'b0;
        end
      endcase
    end
    accept = load_valid && load_ready;
    if (accept) begin
      state_d = SHIFT;
    end else if ((state_q == SHIFT) && last) begin
      state_d = IDLE;
    end
  end

endmodule

// File: tb/tb_piso_serializer_8bit.sv
// tb/tb_piso_serializer_8bit.sv - self-checking bench for piso_serializer_8bit
module tb_piso_serializer_8bit;

`ifdef PISO_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] in;
  logic       load_valid;
  logic       load_ready, serial_out, serial_valid, busy, done;
  logic       m_load_ready, m_serial_out, m_serial_valid, m_busy, m_done;

  logic [1:0] exp_l[$];
  logic [1:0] exp_m[$];
  int         tests;
  int         fails;

  piso_serializer_8bit #(.WIDTH(8), .LSB_FIRST(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .in           (in),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .busy         (busy),
    .done         (done)
  );

  piso_serializer_8bit #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_m (
    .clk          (clk),
    .rst          (rst),
    .in           (in),
    .load_valid   (load_valid),
    .load_ready   (m_load_ready),
    .serial_out   (m_serial_out),
    .serial_valid (m_serial_valid),
    .busy         (m_busy),
    .done         (m_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected entries are {bit, done} for the LSB-first and MSB-first units.
  task automatic push_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      exp_l.push_back({w[i], 1'(i == FRAME - 1)});
      exp_m.push_back({w[7 - i], 1'(i == FRAME - 1)});
    end
`ifdef PISO_PARITY_EN
    exp_l.push_back({^w, 1'b1});
    exp_m.push_back({^w, 1'b1});
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; load_valid = 1'b1; in = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if ({load_ready, serial_out, serial_valid, busy, done, m_load_ready, m_serial_valid} !== 7'b0) begin
        fails++;
        $display("FAIL reset_outputs: got %b want 0000000",
                 {load_ready, serial_out, serial_valid, busy, done, m_load_ready, m_serial_valid});
      end
    end
    rst = 1'b0; load_valid = 1'b0;
    #1;
    tests++;
    if ({load_ready, serial_valid, busy} !== 3'b100) begin
      fails++;
      $display("FAIL reset_release: got {ready,valid,busy}=%b want 100", {load_ready, serial_valid, busy});
    end
  endtask

  // Offer a word from idle; returns at the negedge showing bit 0.
  task automatic start_word(input logic [7:0] w, input string name);
    @(negedge clk);
    load_valid = 1'b1; in = w;
    #1;
    tests++;
    if (load_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s_ready: got %b want 1", name, load_ready);
    end
    push_word(w);
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic test_single(input logic [7:0] w, input string name);
    logic [1:0] e, f;
    start_word(w, name);
    for (int i = 0; i < FRAME; i++) begin
      e = exp_l.pop_front(); f = exp_m.pop_front();
      tests++;
      if ({serial_valid, serial_out, done} !== {1'b1, e}) begin
        fails++;
        $display("FAIL %s_lsb bit %0d: got {v,b,d}=%b want %b", name, i, {serial_valid, serial_out, done}, {1'b1, e});
      end
      tests++;
      if ({m_serial_valid, m_serial_out, m_done} !== {1'b1, f}) begin
        fails++;
        $display("FAIL %s_msb bit %0d: got {v,b,d}=%b want %b", name, i, {m_serial_valid, m_serial_out, m_done}, {1'b1, f});
      end
      @(negedge clk);
    end
    tests++;
    if ({serial_valid, busy, load_ready, done} !== 4'b0010) begin
      fails++;
      $display("FAIL %s_idle: got {v,busy,ready,done}=%b want 0010", name, {serial_valid, busy, load_ready, done});
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] e, f;
    start_word(8'h0F, "b2b");
    for (int i = 0; i < 2 * FRAME; i++) begin
      e = exp_l.pop_front(); f = exp_m.pop_front();
      tests++;
      if ({serial_valid, serial_out, done} !== {1'b1, e}) begin
        fails++;
        $display("FAIL b2b_lsb bit %0d: got {v,b,d}=%b want %b", i, {serial_valid, serial_out, done}, {1'b1, e});
      end
      tests++;
      if ({m_serial_valid, m_serial_out, m_done} !== {1'b1, f}) begin
        fails++;
        $display("FAIL b2b_msb bit %0d: got {v,b,d}=%b want %b", i, {m_serial_valid, m_serial_out, m_done}, {1'b1, f});
      end
      if (i == FRAME - 1) begin
        tests++;
        if (load_ready !== 1'b1) begin
          fails++;
          $display("FAIL b2b_reload_ready: got %b want 1", load_ready);
        end
        load_valid = 1'b1; in = 8'hF0;
        push_word(8'hF0);
      end
      if (i == FRAME) load_valid = 1'b0;
      @(negedge clk);
    end
    tests++;
    if ({serial_valid, busy} !== 2'b00) begin
      fails++;
      $display("FAIL b2b_idle: got {v,busy}=%b want 00", {serial_valid, busy});
    end
  endtask

  task automatic test_midframe_offer();
    logic [1:0] e;
    start_word(8'hA5, "mid");
    for (int i = 0; i < FRAME; i++) begin
      e = exp_l.pop_front();
      void'(exp_m.pop_front());
      tests++;
      if ({serial_valid, serial_out, done} !== {1'b1, e}) begin
        fails++;
        $display("FAIL mid_lsb bit %0d: got {v,b,d}=%b want %b", i, {serial_valid, serial_out, done}, {1'b1, e});
      end
      if (i == 3) begin
        tests++;
        if (load_ready !== 1'b0) begin
          fails++;
          $display("FAIL mid_ready: got %b want 0", load_ready);
        end
        load_valid = 1'b1; in = 8'h3C;
      end
      if (i == 4) load_valid = 1'b0;
      @(negedge clk);
    end
    tests++;
    if (serial_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_idle: got valid=%b want 0", serial_valid);
    end
  endtask

  task automatic test_reset_midframe();
    logic [1:0] e;
    start_word(8'hA5, "rstmid");
    for (int i = 0; i < 4; i++) begin
      e = exp_l.pop_front();
      tests++;
      if ({serial_valid, serial_out, done} !== {1'b1, e}) begin
        fails++;
        $display("FAIL rstmid_lsb bit %0d: got {v,b,d}=%b want %b", i, {serial_valid, serial_out, done}, {1'b1, e});
      end
      @(negedge clk);
    end
    exp_l.delete();
    exp_m.delete();
    rst = 1'b1;
    #1;
    tests++;
    if ({serial_valid, done, m_serial_valid, m_done} !== 4'b0000) begin
      fails++;
      $display("FAIL rstmid_abort: got {v,d,mv,md}=%b want 0000", {serial_valid, done, m_serial_valid, m_done});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if ({serial_valid, busy, done, load_ready} !== 4'b0001) begin
      fails++;
      $display("FAIL rstmid_after: got {v,busy,d,ready}=%b want 0001", {serial_valid, busy, done, load_ready});
    end
    test_single(8'h81, "after_rst");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single(8'hA5, "single_a5");
    test_back_to_back();
    test_midframe_offer();
    test_reset_midframe();
    test_single(8'h07, "word_07");
    test_single(8'($urandom), "random");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
